// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_pkg
// Purpose : Shared types and constants for the memory arbiter. It holds the
//           transfer size codes, the arbiter FSM states, the requester
//           indices, the pending-request record and the round-robin helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Transfer size codes. SZ_NONE on a request input means "no request".
    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } size_e;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDATA  = 2'd2,
        RESP   = 2'd3
    } state_e;

    // Requester indices, in round-robin order.
    localparam logic [1:0] C_REQ_CPU_RD = 2'd0;
    localparam logic [1:0] C_REQ_CPU_WR = 2'd1;
    localparam logic [1:0] C_REQ_DMA    = 2'd2;
    localparam int         C_NUM_REQ    = 3;

    // One captured request: full byte address, right-aligned data, size, direction.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic        we;
    } req_t;

    // Next requester index in the cyclic order 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == C_REQ_DMA) ? C_REQ_CPU_RD : idx + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_fmt.sv
`default_nettype none
// ============================================================================
// Module  : mem_lane_fmt
// Purpose : Combinational byte-lane formatter for a 32-bit RAM word.
//           Produces the byte enables, the replicated write data, the
//           right-aligned zero-extended read lane and the misalign flag.
//           Misaligned half/word accesses use the aligned-down lanes.
// Ports   : i_addr_lo  - byte address bits [1:0]
//           i_size     - size code (SZ_BYTE / SZ_HALF / SZ_WORD)
//           i_wdata    - right-aligned write data
//           i_rdata    - raw RAM read word
//           o_be       - RAM byte enables
//           o_wdata    - write data replicated across lanes
//           o_rdata    - selected read lane, zero-extended
//           o_misalign - access not naturally aligned for its size
// Revision: 1.0 - initial release
// ============================================================================
module mem_lane_fmt
    import mem_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    always_comb begin
        o_be       = 4'b0000;
        o_wdata    = i_wdata;
        o_rdata    = 32'h0;
        o_misalign = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                case (i_addr_lo)
                    2'd0:    o_rdata = {24'h0, i_rdata[7:0]};
                    2'd1:    o_rdata = {24'h0, i_rdata[15:8]};
                    2'd2:    o_rdata = {24'h0, i_rdata[23:16]};
                    default: o_rdata = {24'h0, i_rdata[31:24]};
                endcase
            end
            SZ_HALF: begin
                // Only addr[1] picks the half; addr[0] is ignored (aligned down).
                o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_wdata[15:0]}};
                o_rdata    = i_addr_lo[1] ? {16'h0, i_rdata[31:16]} : {16'h0, i_rdata[15:0]};
                o_misalign = i_addr_lo[0];
            end
            SZ_WORD: begin
                o_be       = 4'b1111;
                o_wdata    = i_wdata;
                o_rdata    = i_rdata;
                o_misalign = |i_addr_lo;
            end
            default: begin
                o_be = 4'b0000;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Purpose : Round-robin arbiter that shares one single-port 32-bit RAM
//           between a CPU read port, a CPU write port and a DMA port. Each
//           requester has a one-deep pending slot. Accesses run through
//           IDLE -> ACCESS -> (RDATA) -> RESP.
// Ports   : clk, reset                      - clock, sync active-high reset
//           c_in_addr/c_in_sig_read         - CPU read request
//           c_in_ready/c_in_data            - CPU read completion / data
//           c_out_addr/c_out_data/
//           c_out_sig_write                 - CPU write request
//           c_out_ready                     - CPU write completion
//           d_addr/d_wdata/d_sig/d_we       - DMA request
//           d_ready/d_rdata                 - DMA completion / read data
//           ram_en/ram_we/ram_be/
//           ram_addr/ram_wdata/ram_rdata    - single-port RAM interface
//           misalign/overflow               - one-cycle error pulses
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int RAM_AW = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       c_in_addr,
    input  logic [1:0]        c_in_sig_read,
    output logic              c_in_ready,
    output logic [31:0]       c_in_data,
    input  logic [31:0]       c_out_addr,
    input  logic [31:0]       c_out_data,
    input  logic [1:0]        c_out_sig_write,
    output logic              c_out_ready,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [1:0]        d_sig,
    input  logic              d_we,
    output logic              d_ready,
    output logic [31:0]       d_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [3:0]        ram_be,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              misalign,
    output logic              overflow
);

    state_e      r_state;
    state_e      w_state_nxt;
    req_t        r_slot [0:C_NUM_REQ-1];
    logic [2:0]  r_pend;
    logic [1:0]  r_last;
    req_t        r_cur;
    logic [1:0]  r_cur_idx;
    logic [31:0] r_rdata;
    logic        r_overflow;

    req_t        w_in [0:C_NUM_REQ-1];
    logic [2:0]  w_sig_valid;
    logic        w_grant;
    logic [1:0]  w_grant_idx;
    logic [2:0]  w_grant_mask;
    logic [1:0]  w_c1;
    logic [1:0]  w_c2;
    logic [1:0]  w_c3;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_rep;
    logic [31:0] w_rdata_ext;
    logic        w_misalign;
    logic        w_unused_addr_hi;

    // Address bits above the RAM window are deliberately dropped (wrap).
    assign w_unused_addr_hi = ^r_cur.addr[31:RAM_AW+2];

    // Normalise the three request ports into common records.
    always_comb begin
        w_in[C_REQ_CPU_RD] = '{addr: c_in_addr,  data: 32'h0,      size: c_in_sig_read,   we: 1'b0};
        w_in[C_REQ_CPU_WR] = '{addr: c_out_addr, data: c_out_data, size: c_out_sig_write, we: 1'b1};
        w_in[C_REQ_DMA]    = '{addr: d_addr,     data: d_wdata,    size: d_sig,           we: d_we};
        w_sig_valid        = {|d_sig, |c_out_sig_write, |c_in_sig_read};
    end

    // Round-robin pick: search starts just after the last granted index.
    always_comb begin
        w_c1 = rr_next(r_last);
        w_c2 = rr_next(w_c1);
        w_c3 = rr_next(w_c2);
        w_grant = (r_state == IDLE) && (|r_pend);
        if (r_pend[w_c1]) begin
            w_grant_idx = w_c1;
        end else if (r_pend[w_c2]) begin
            w_grant_idx = w_c2;
        end else begin
            w_grant_idx = w_c3;
        end
        w_grant_mask = w_grant ? (3'b001 << w_grant_idx) : 3'b000;
    end

    // Pending slots. A pulse into a busy slot is dropped unless that slot is
    // being granted in the same cycle, in which case the new pulse refills it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend     <= 3'b000;
            r_overflow <= 1'b0;
            for (int i = 0; i < C_NUM_REQ; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            r_overflow <= |(w_sig_valid & r_pend & ~w_grant_mask);
            for (int i = 0; i < C_NUM_REQ; i++) begin
                if (w_sig_valid[i] && (!r_pend[i] || w_grant_mask[i])) begin
                    r_pend[i] <= 1'b1;
                    r_slot[i] <= w_in[i];
                end else if (w_grant_mask[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    // Granted request and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur     <= '0;
            r_cur_idx <= C_REQ_CPU_RD;
            r_last    <= C_REQ_DMA;
        end else if (w_grant) begin
            r_cur     <= r_slot[w_grant_idx];
            r_cur_idx <= w_grant_idx;
            r_last    <= w_grant_idx;
        end
    end

    // Shared read-data register; holds its value between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= 32'h0;
        end else if (r_state == RDATA) begin
            r_rdata <= w_rdata_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    mem_lane_fmt u_lane_fmt (
        .i_addr_lo  (r_cur.addr[1:0]),
        .i_size     (r_cur.size),
        .i_wdata    (r_cur.data),
        .i_rdata    (ram_rdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata_rep),
        .o_rdata    (w_rdata_ext),
        .o_misalign (w_misalign)
    );

    // Next state and state-decoded outputs.
    always_comb begin
        w_state_nxt = r_state;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_be      = 4'b0000;
        ram_addr    = '0;
        ram_wdata   = 32'h0;
        misalign    = 1'b0;
        c_in_ready  = 1'b0;
        c_out_ready = 1'b0;
        d_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                if (|r_pend) begin
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                ram_en      = 1'b1;
                ram_we      = r_cur.we;
                ram_be      = w_be;
                ram_addr    = r_cur.addr[RAM_AW+1:2];
                ram_wdata   = w_wdata_rep;
                misalign    = w_misalign;
                w_state_nxt = r_cur.we ? RESP : RDATA;
            end
            RDATA: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                c_in_ready  = (r_cur_idx == C_REQ_CPU_RD);
                c_out_ready = (r_cur_idx == C_REQ_CPU_WR);
                d_ready     = (r_cur_idx == C_REQ_DMA);
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign c_in_data = r_rdata;
    assign d_rdata   = r_rdata;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Purpose : Directed self-checking bench for mem_arbiter with a behavioural
//           single-port RAM. Cycle k of a scenario is sampled on the k-th
//           falling edge after the request pulse was driven (cycle 0).
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] c_in_addr;
    logic [1:0]  c_in_sig_read;
    logic        c_in_ready;
    logic [31:0] c_in_data;
    logic [31:0] c_out_addr;
    logic [31:0] c_out_data;
    logic [1:0]  c_out_sig_write;
    logic        c_out_ready;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_sig;
    logic        d_we;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        ram_en;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [13:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        misalign;
    logic        overflow;
    logic        preload;

    int n_tests;
    int n_fail;

    mem_arbiter #(.RAM_AW(14)) dut (
        .clk             (clk),
        .reset           (reset),
        .c_in_addr       (c_in_addr),
        .c_in_sig_read   (c_in_sig_read),
        .c_in_ready      (c_in_ready),
        .c_in_data       (c_in_data),
        .c_out_addr      (c_out_addr),
        .c_out_data      (c_out_data),
        .c_out_sig_write (c_out_sig_write),
        .c_out_ready     (c_out_ready),
        .d_addr          (d_addr),
        .d_wdata         (d_wdata),
        .d_sig           (d_sig),
        .d_we            (d_we),
        .d_ready         (d_ready),
        .d_rdata         (d_rdata),
        .ram_en          (ram_en),
        .ram_we          (ram_we),
        .ram_be          (ram_be),
        .ram_addr        (ram_addr),
        .ram_wdata       (ram_wdata),
        .ram_rdata       (ram_rdata),
        .misalign        (misalign),
        .overflow        (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM: read data valid the cycle after ram_en.
    logic [31:0] mem [0:16383] = '{default: 32'h0};
    always @(posedge clk) begin
        if (preload) begin
            mem[4]    <= 32'hDEADBEEF;
            mem[8]    <= 32'h1234ABCD;
            ram_rdata <= 32'h0;
        end else if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_be[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
                end
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    // Per-cycle observation record for one scenario window.
    logic        ob_cir [0:31];
    logic        ob_cor [0:31];
    logic        ob_dr  [0:31];
    logic        ob_en  [0:31];
    logic        ob_we  [0:31];
    logic        ob_mis [0:31];
    logic        ob_ovf [0:31];
    logic [3:0]  ob_be  [0:31];
    logic [13:0] ob_addr[0:31];
    logic [31:0] ob_wd  [0:31];
    logic [31:0] ob_cid [0:31];
    logic [31:0] ob_drd [0:31];

    // Step n cycles after a pulse, dropping all request pulses after cycle 0.
    // Optionally re-pulses the DMA port in cycle d2_at.
    task automatic run_window(input int n, input int d2_at, input logic [31:0] d2_addr,
                              input logic [1:0] d2_sig);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (k == 1) begin
                c_in_sig_read = 2'd0; c_out_sig_write = 2'd0; d_sig = 2'd0;
            end
            if (k == d2_at) begin
                d_addr = d2_addr; d_sig = d2_sig; d_we = 1'b0;
            end else if (d2_at != 0 && k == d2_at + 1) begin
                d_sig = 2'd0;
            end
            ob_cir[k] = c_in_ready; ob_cor[k] = c_out_ready; ob_dr[k] = d_ready;
            ob_en[k] = ram_en; ob_we[k] = ram_we; ob_mis[k] = misalign; ob_ovf[k] = overflow;
            ob_be[k] = ram_be; ob_addr[k] = ram_addr; ob_wd[k] = ram_wdata;
            ob_cid[k] = c_in_data; ob_drd[k] = d_rdata;
        end
    endtask

    // Pulse count and first cycle of a recorded 1-bit signal.
    task automatic pulses(input int sel, input int n, output int count, output int first);
        logic v;
        count = 0; first = 0;
        for (int k = 1; k <= n; k++) begin
            case (sel)
                0: v = ob_cir[k];
                1: v = ob_cor[k];
                2: v = ob_dr[k];
                3: v = ob_mis[k];
                4: v = ob_ovf[k];
                default: v = ob_en[k];
            endcase
            if (v === 1'b1) begin
                count++;
                if (first == 0) first = k;
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] a, input logic [1:0] sz);
        @(negedge clk);
        c_in_addr = a; c_in_sig_read = sz;
    endtask

    task automatic test_reset();
        // reset is held high on entry
        n_tests++;
        if ({c_in_ready, c_out_ready, d_ready, ram_en, ram_we, misalign, overflow} !== 7'h0) begin
            n_fail++; $display("FAIL reset_ctl got %b required 0",
                {c_in_ready, c_out_ready, d_ready, ram_en, ram_we, misalign, overflow});
        end
        n_tests++;
        if ({ram_be, ram_addr, ram_wdata} !== 50'h0) begin
            n_fail++; $display("FAIL reset_ram got be=%h addr=%h wd=%h required 0", ram_be, ram_addr, ram_wdata);
        end
        n_tests++;
        if ({c_in_data, d_rdata} !== 64'h0) begin
            n_fail++; $display("FAIL reset_rdata got %h/%h required 0", c_in_data, d_rdata);
        end
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (ram_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle ram_en got %b required 0", ram_en);
        end
    endtask

    task automatic test_word_read();
        int c, f;
        cpu_read(32'h10, 2'd3);
        run_window(8, 0, 32'h0, 2'd0);
        n_tests++;
        if ({ob_en[1], ob_en[2], ob_en[3]} !== 3'b010) begin
            n_fail++; $display("FAIL wr_en got %b required 010", {ob_en[1], ob_en[2], ob_en[3]});
        end
        n_tests++;
        if ({ob_we[2], ob_be[2], ob_addr[2]} !== {1'b0, 4'hF, 14'd4}) begin
            n_fail++; $display("FAIL wr_cmd got we=%b be=%h addr=%0d required we=0 be=f addr=4",
                ob_we[2], ob_be[2], ob_addr[2]);
        end
        pulses(0, 8, c, f);
        n_tests++;
        if (c != 1 || f != 4) begin
            n_fail++; $display("FAIL wr_ready got count=%0d cycle=%0d required 1 at 4", c, f);
        end
        n_tests++;
        if (ob_cid[4] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL wr_data got %h required deadbeef", ob_cid[4]);
        end
        pulses(3, 8, c, f);
        n_tests++;
        if (c != 0) begin
            n_fail++; $display("FAIL wr_misalign got %0d pulses required 0", c);
        end
    endtask

    task automatic test_byte_write();
        int c, f;
        @(negedge clk);
        c_out_addr = 32'h13; c_out_data = 32'h000000AB; c_out_sig_write = 2'd1;
        run_window(6, 0, 32'h0, 2'd0);
        n_tests++;
        if ({ob_en[2], ob_we[2], ob_be[2], ob_addr[2]} !== {1'b1, 1'b1, 4'b1000, 14'd4}) begin
            n_fail++; $display("FAIL bw_cmd got en=%b we=%b be=%b addr=%0d required 1 1 1000 4",
                ob_en[2], ob_we[2], ob_be[2], ob_addr[2]);
        end
        n_tests++;
        if (ob_wd[2] !== 32'hABABABAB) begin
            n_fail++; $display("FAIL bw_wdata got %h required abababab", ob_wd[2]);
        end
        pulses(1, 6, c, f);
        n_tests++;
        if (c != 1 || f != 3) begin
            n_fail++; $display("FAIL bw_ready got count=%0d cycle=%0d required 1 at 3", c, f);
        end
        n_tests++;
        if (mem[4] !== 32'hABADBEEF) begin
            n_fail++; $display("FAIL bw_ram got %h required abadbeef", mem[4]);
        end
    endtask

    task automatic test_lanes_and_wrap();
        int c, f;
        // aligned half, upper lanes
        cpu_read(32'h22, 2'd2);
        run_window(8, 0, 32'h0, 2'd0);
        pulses(3, 8, c, f);
        n_tests++;
        if (ob_cid[4] !== 32'h00001234 || ob_be[2] !== 4'b1100 || c != 0) begin
            n_fail++; $display("FAIL half22 got data=%h be=%b mis=%0d required 00001234 1100 0",
                ob_cid[4], ob_be[2], c);
        end
        // misaligned half -> lower lanes
        cpu_read(32'h21, 2'd2);
        run_window(8, 0, 32'h0, 2'd0);
        pulses(3, 8, c, f);
        n_tests++;
        if (ob_cid[4] !== 32'h0000ABCD || ob_be[2] !== 4'b0011) begin
            n_fail++; $display("FAIL half21 got data=%h be=%b required 0000abcd 0011", ob_cid[4], ob_be[2]);
        end
        n_tests++;
        if (c != 1 || f != 2) begin
            n_fail++; $display("FAIL half21_mis got count=%0d cycle=%0d required 1 at 2", c, f);
        end
        // byte read of the byte written earlier
        cpu_read(32'h13, 2'd1);
        run_window(8, 0, 32'h0, 2'd0);
        n_tests++;
        if (ob_cid[4] !== 32'h000000AB || ob_be[2] !== 4'b1000) begin
            n_fail++; $display("FAIL byte13 got data=%h be=%b required 000000ab 1000", ob_cid[4], ob_be[2]);
        end
        // misaligned word
        cpu_read(32'h12, 2'd3);
        run_window(8, 0, 32'h0, 2'd0);
        n_tests++;
        if (ob_cid[4] !== 32'hABADBEEF || ob_mis[2] !== 1'b1 || ob_be[2] !== 4'hF) begin
            n_fail++; $display("FAIL word12 got data=%h mis=%b be=%h required abadbeef 1 f",
                ob_cid[4], ob_mis[2], ob_be[2]);
        end
        // high address bits wrap
        cpu_read(32'h0001_0010, 2'd3);
        run_window(8, 0, 32'h0, 2'd0);
        n_tests++;
        if (ob_addr[2] !== 14'd4 || ob_cid[4] !== 32'hABADBEEF) begin
            n_fail++; $display("FAIL wrap got addr=%0d data=%h required 4 abadbeef", ob_addr[2], ob_cid[4]);
        end
    endtask

    task automatic test_contention();
        int c, f;
        do_reset(2);
        @(negedge clk);
        c_in_addr = 32'h10; c_in_sig_read = 2'd3;
        c_out_addr = 32'h14; c_out_data = 32'h55AA55AA; c_out_sig_write = 2'd3;
        d_addr = 32'h22; d_sig = 2'd2; d_we = 1'b0;
        run_window(16, 0, 32'h0, 2'd0);
        pulses(0, 16, c, f);
        n_tests++;
        if (c != 1 || f != 4 || ob_cid[4] !== 32'hABADBEEF) begin
            n_fail++; $display("FAIL cont_rd got count=%0d cycle=%0d data=%h required 1 at 4 abadbeef",
                c, f, ob_cid[4]);
        end
        pulses(1, 16, c, f);
        n_tests++;
        if (c != 1 || f != 7 || ob_addr[6] !== 14'd5 || ob_we[6] !== 1'b1) begin
            n_fail++; $display("FAIL cont_wr got count=%0d cycle=%0d addr=%0d we=%b required 1 at 7 5 1",
                c, f, ob_addr[6], ob_we[6]);
        end
        pulses(2, 16, c, f);
        n_tests++;
        if (c != 1 || f != 11 || ob_drd[11] !== 32'h00001234 || ob_addr[9] !== 14'd8) begin
            n_fail++; $display("FAIL cont_dma got count=%0d cycle=%0d data=%h addr=%0d required 1 at 11 00001234 8",
                c, f, ob_drd[11], ob_addr[9]);
        end
        n_tests++;
        if (mem[5] !== 32'h55AA55AA) begin
            n_fail++; $display("FAIL cont_ram got %h required 55aa55aa", mem[5]);
        end
    endtask

    task automatic test_overflow();
        int c, f;
        @(negedge clk);
        c_in_addr = 32'h10; c_in_sig_read = 2'd3;
        d_addr = 32'h14; d_sig = 2'd3; d_we = 1'b0;
        run_window(14, 2, 32'h22, 2'd2);
        pulses(4, 14, c, f);
        n_tests++;
        if (c != 1 || f != 3) begin
            n_fail++; $display("FAIL ovf_pulse got count=%0d cycle=%0d required 1 at 3", c, f);
        end
        pulses(2, 14, c, f);
        n_tests++;
        if (c != 1 || f != 8 || ob_drd[8] !== 32'h55AA55AA) begin
            n_fail++; $display("FAIL ovf_dma got count=%0d cycle=%0d data=%h required 1 at 8 55aa55aa",
                c, f, ob_drd[8]);
        end
        pulses(0, 14, c, f);
        n_tests++;
        if (c != 1 || f != 4) begin
            n_fail++; $display("FAIL ovf_cpu got count=%0d cycle=%0d required 1 at 4", c, f);
        end
    endtask

    task automatic test_reset_midop();
        int rdy, en;
        rdy = 0; en = 0;
        cpu_read(32'h10, 2'd3);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) c_in_sig_read = 2'd0;
            if (k == 3) begin
                // cycle 3 is RDATA; reset and a DMA pulse land here together
                reset = 1'b1; d_addr = 32'h10; d_sig = 2'd3; d_we = 1'b0;
            end
            if (k == 4) begin
                reset = 1'b0; d_sig = 2'd0;
                n_tests++;
                if ({c_in_ready, c_out_ready, d_ready, ram_en, misalign, overflow} !== 6'h0 ||
                    c_in_data !== 32'h0 || d_rdata !== 32'h0 || ram_be !== 4'h0) begin
                    n_fail++; $display("FAIL rstmid_out got ctl=%b cdata=%h ddata=%h be=%h required 0",
                        {c_in_ready, c_out_ready, d_ready, ram_en, misalign, overflow},
                        c_in_data, d_rdata, ram_be);
                end
            end
            if (c_in_ready === 1'b1 || d_ready === 1'b1 || c_out_ready === 1'b1) rdy++;
            if (k >= 4 && ram_en === 1'b1) en++;
        end
        n_tests++;
        if (rdy != 0 || en != 0) begin
            n_fail++; $display("FAIL rstmid_quiet got ready=%0d ram_en=%0d required 0 0", rdy, en);
        end
        cpu_read(32'h22, 2'd2);
        run_window(8, 0, 32'h0, 2'd0);
        pulses(0, 8, rdy, en);
        n_tests++;
        if (rdy != 1 || en != 4 || ob_cid[4] !== 32'h00001234) begin
            n_fail++; $display("FAIL rstmid_next got count=%0d cycle=%0d data=%h required 1 at 4 00001234",
                rdy, en, ob_cid[4]);
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        reset = 1'b1; preload = 1'b1;
        c_in_addr = 32'h0; c_in_sig_read = 2'd0;
        c_out_addr = 32'h0; c_out_data = 32'h0; c_out_sig_write = 2'd0;
        d_addr = 32'h0; d_wdata = 32'h0; d_sig = 2'd0; d_we = 1'b0;
        repeat (3) @(negedge clk);
        preload = 1'b0;
        @(negedge clk);
        test_reset();
        test_word_read();
        test_byte_write();
        test_lanes_and_wrap();
        test_contention();
        test_overflow();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
